dff_reg: RTL and testbench
==========================

Name: dff_reg

Overview:
- Parameterised-width D flip-flop register; the basic storage primitive of the block library.
- Captures the `in` bus on every rising edge of `clk` and presents it on `out` one cycle later.
- Used wherever the design needs a single-stage pipeline register or a state register.
- Has no enable and no handshake; it is a pure registered copy with a synchronous reset.

Parameters:
- WIDTH, default 1: bit width of `in` and `out`. Legal range is 1 to 1024.
- RESET_VALUE, default 0 (WIDTH bits): value loaded into `out` when reset is asserted.

Ports:
- clk  input  1  clock. All state updates happen on the rising edge only.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  data captured on each rising edge of clk.
- out  output  WIDTH  registered data.
- out_parity  output  1  even parity of `out`. Present only when DFF_PARITY_EN is defined.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; there is no asynchronous path.
- At each posedge clk:
  - if rst == 1, then out <= RESET_VALUE;
  - otherwise out <= in.
- Latency is exactly one clock. Changes on `in` between edges have no effect on `out`.
- `out` changes only immediately after a rising edge. Falling edges are ignored.
- Reset and data at the same edge: reset wins, so out = RESET_VALUE.
- Reset deasserted: the first edge with rst == 0 captures `in`.
- Reset mid-stream: the value in flight is discarded. `out` takes RESET_VALUE at the next edge and holds it while rst stays high.
- rst left unconnected or X/Z: treated as not asserted, so the register behaves as a plain DFF.
- Before the first clock edge, with no reset applied, `out` is undefined (X in simulation).
- No arithmetic. Width is preserved bit-for-bit, with no truncation or extension.
- RESET_VALUE is truncated to WIDTH bits if it is wider than WIDTH.
- X on `in` propagates to `out` on the next edge unchanged.
- Implement as one always block on posedge clk using non-blocking assignment. No latches, no combinational feedback.

Optional Feature:
- Macro: DFF_PARITY_EN.
- When defined:
  - adds output port `out_parity`, a registered signal equal to the XOR reduction of the value loaded into `out`;
  - at reset, out_parity = XOR reduction of RESET_VALUE[WIDTH-1:0];
  - out_parity updates on the same edge as `out`, with the same one-cycle latency.
- When not defined:
  - the port and its logic do not exist;
  - the module has only clk, rst, in and out.

Test Plan:
- Basic capture: WIDTH=2, rst=0, drive in=2'b01 just after an edge -> out=2'b01 after the next posedge and holds while `in` is stable.
- Update sequence: in changes 01 -> 11 -> 10 on consecutive cycles -> out follows 01, 11, 10, each one edge late, never early.
- Randomized data: random in values 0 to 3 on each of 3 cycles, then `in` held for 2 cycles -> out equals the held `in` after one edge; every cycle, out equals the `in` sampled at the prior edge.
- Reset priority: RESET_VALUE=2'b10, rst=1 with in=2'b01 -> out=2'b10. Deassert rst -> out=2'b01 at the next edge.
- Reset mid-stream: in toggling every cycle, pulse rst for 1 cycle -> out=RESET_VALUE for exactly that edge, then resumes tracking `in`.
- Parity, with DFF_PARITY_EN defined, WIDTH=2: in=2'b11 -> out_parity=0; in=2'b01 -> out_parity=1; both aligned with `out`.

Source files
------------

// File: rtl/dff_reg.sv
// Parameterised-width D flip-flop with synchronous active-high reset.
// Optional registered even-parity output when DFF_PARITY_EN is defined.
module dff_reg #(
  parameter int unsigned            WIDTH       = 1,
  parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
`ifdef DFF_PARITY_EN
  output logic             out_parity,
`endif
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_data;

`ifdef DFF_PARITY_EN
  logic r_parity;

  function automatic logic f_even_parity(input logic [WIDTH-1:0] value);
    return ^value;
  endfunction

  // Data and parity share one edge so out_parity always describes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= RESET_VALUE;
      r_parity <= f_even_parity(RESET_VALUE);
    end else begin
      r_data   <= in;
      r_parity <= f_even_parity(in);
    end
  end

  assign out_parity = r_parity;
`else
  // An X/Z reset falls through to the capture branch, giving a plain DFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= RESET_VALUE;
    end else begin
      r_data <= in;
    end
  end
`endif

  assign out = r_data;

endmodule

// File: tb/tb_dff_reg.sv
// Directed self-checking bench for dff_reg (WIDTH=2, RESET_VALUE=2'b10).
module tb_dff_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic [1:0] out;
`ifdef DFF_PARITY_EN
  logic       out_parity;
`endif
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_reg #(.WIDTH(2), .RESET_VALUE(2'b10)) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
`ifdef DFF_PARITY_EN
    .out_parity(out_parity),
`endif
    .out(out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in  = 2'b01;
    step();
    checks++;
    if (out !== 2'b10) begin
      failures++;
      $display("FAIL reset_value out=%b expected=%b", out, 2'b10);
    end
    step();
    checks++;
    if (out !== 2'b10) begin
      failures++;
      $display("FAIL reset_hold out=%b expected=%b", out, 2'b10);
    end
`ifdef DFF_PARITY_EN
    checks++;
    if (out_parity !== 1'b1) begin
      failures++;
      $display("FAIL reset_parity out_parity=%b expected=%b", out_parity, 1'b1);
    end
`endif
    rst = 1'b0;
    step();
    checks++;
    if (out !== 2'b01) begin
      failures++;
      $display("FAIL reset_release out=%b expected=%b", out, 2'b01);
    end
  endtask

  task automatic test_basic_capture();
    in = 2'b11;
    step();
    in = 2'b01;
    checks++;
    if (out !== 2'b11) begin
      failures++;
      $display("FAIL capture_early out=%b expected=%b", out, 2'b11);
    end
    step();
    checks++;
    if (out !== 2'b01) begin
      failures++;
      $display("FAIL capture out=%b expected=%b", out, 2'b01);
    end
    @(negedge clk);
    checks++;
    if (out !== 2'b01) begin
      failures++;
      $display("FAIL capture_negedge out=%b expected=%b", out, 2'b01);
    end
    step();
    checks++;
    if (out !== 2'b01) begin
      failures++;
      $display("FAIL capture_hold out=%b expected=%b", out, 2'b01);
    end
  endtask

  task automatic test_between_edges();
    in = 2'b11;
    @(negedge clk);
    checks++;
    if (out !== 2'b01) begin
      failures++;
      $display("FAIL mid_cycle_change out=%b expected=%b", out, 2'b01);
    end
    in = 2'b00;
    step();
    checks++;
    if (out !== 2'b00) begin
      failures++;
      $display("FAIL last_value_wins out=%b expected=%b", out, 2'b00);
    end
  endtask

  task automatic test_update_sequence();
    logic [1:0] seq [3];
    logic [1:0] prev;
    seq[0] = 2'b01;
    seq[1] = 2'b11;
    seq[2] = 2'b10;
    prev   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in = seq[i];
      #1;
      checks++;
      if (out !== prev) begin
        failures++;
        $display("FAIL seq_not_early[%0d] out=%b expected=%b", i, out, prev);
      end
      step();
      checks++;
      if (out !== seq[i]) begin
        failures++;
        $display("FAIL seq_follow[%0d] out=%b expected=%b", i, out, seq[i]);
      end
`ifdef DFF_PARITY_EN
      checks++;
      if (out_parity !== (^seq[i])) begin
        failures++;
        $display("FAIL seq_parity[%0d] out_parity=%b expected=%b", i, out_parity, ^seq[i]);
      end
`endif
      prev = seq[i];
    end
  endtask

  task automatic test_random();
    logic [1:0] sampled;
    for (int i = 0; i < 3; i++) begin
      sampled = 2'($urandom_range(0, 3));
      in = sampled;
      step();
      checks++;
      if (out !== sampled) begin
        failures++;
        $display("FAIL random[%0d] out=%b expected=%b", i, out, sampled);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out !== sampled) begin
        failures++;
        $display("FAIL random_hold[%0d] out=%b expected=%b", i, out, sampled);
      end
    end
  endtask

  task automatic test_reset_midstream();
    in = 2'b10;
    step();
    checks++;
    if (out !== 2'b10) begin
      failures++;
      $display("FAIL mid_pre out=%b expected=%b", out, 2'b10);
    end
    in  = 2'b01;
    rst = 1'b1;
    step();
    checks++;
    if (out !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset out=%b expected=%b", out, 2'b10);
    end
    rst = 1'b0;
    in  = 2'b11;
    step();
    checks++;
    if (out !== 2'b11) begin
      failures++;
      $display("FAIL mid_resume out=%b expected=%b", out, 2'b11);
    end
    in = 2'b00;
    step();
    checks++;
    if (out !== 2'b00) begin
      failures++;
      $display("FAIL mid_track out=%b expected=%b", out, 2'b00);
    end
  endtask

`ifdef DFF_PARITY_EN
  task automatic test_parity();
    in = 2'b11;
    step();
    checks++;
    if (out !== 2'b11 || out_parity !== 1'b0) begin
      failures++;
      $display("FAIL parity_11 out=%b out_parity=%b expected=11/0", out, out_parity);
    end
    in = 2'b01;
    step();
    checks++;
    if (out !== 2'b01 || out_parity !== 1'b1) begin
      failures++;
      $display("FAIL parity_01 out=%b out_parity=%b expected=01/1", out, out_parity);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    in  = 2'b00;
    #1;
    test_reset();
    test_basic_capture();
    test_between_edges();
    test_update_sequence();
    test_random();
    test_reset_midstream();
`ifdef DFF_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
